// File: rtl/alu_pipe.sv
// Pipelined ALU with valid/ready handshakes, registered flags and an
// iterative shift-add unsigned multiply producing a double-width product.
module alu_pipe #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       Control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Answer,
  output logic [WIDTH-1:0] Answer_hi,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v,
  output logic             flag_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b0010;
  localparam logic [3:0] OP_OR    = 4'b0011;
  localparam logic [3:0] OP_XOR   = 4'b0100;
  localparam logic [3:0] OP_NOT   = 4'b0101;
  localparam logic [3:0] OP_SHL   = 4'b0110;
  localparam logic [3:0] OP_SHR   = 4'b0111;
  localparam logic [3:0] OP_SAR   = 4'b1000;
  localparam logic [3:0] OP_SLT   = 4'b1001;
  localparam logic [3:0] OP_SLTU  = 4'b1010;
  localparam logic [3:0] OP_MUL   = 4'b1011;
  localparam logic [3:0] OP_PASSB = 4'b1100;

  localparam logic [SHW:0] COUNT_INIT = (SHW+1)'(WIDTH);
  localparam logic [SHW:0] COUNT_LAST = (SHW+1)'(1);

  logic [1:0]         state;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   mplier;
  logic [SHW:0]       count;

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [SHW-1:0]     amt;
  logic [WIDTH-1:0]   res;
  logic               res_c;
  logic               res_v;
  logic               res_err;

  assign in_ready  = ~rst & (state == S_IDLE);
  assign out_valid = (state == S_DONE);

  assign sum      = {1'b0, A} + {1'b0, B};
  assign diff     = {1'b0, A} - {1'b0, B};
  assign amt      = B[SHW-1:0];
  assign acc_next = mplier[0] ? acc + mcand : acc;

  // Single-cycle result for every opcode except MUL; the top bit of diff is the borrow.
  always_comb begin
    res     = '0;
    res_c   = 1'b0;
    res_v   = 1'b0;
    res_err = 1'b0;
    case (Control)
      OP_ADD: begin
        res   = sum[WIDTH-1:0];
        res_c = sum[WIDTH];
        res_v = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        res   = diff[WIDTH-1:0];
        res_c = diff[WIDTH];
        res_v = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
      end
      OP_AND:   res = A & B;
      OP_OR:    res = A | B;
      OP_XOR:   res = A ^ B;
      OP_NOT:   res = ~A;
      OP_SHL:   res = A << amt;
      OP_SHR:   res = A >> amt;
      OP_SAR:   res = $signed(A) >>> amt;
      OP_SLT:   res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLTU:  res = {{(WIDTH-1){1'b0}}, (A < B)};
      OP_MUL:   res = '0;
      OP_PASSB: res = B;
      default:  res_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      mcand     <= '0;
      acc       <= '0;
      mplier    <= '0;
      count     <= '0;
      Answer    <= '0;
      Answer_hi <= '0;
      flag_z    <= 1'b0;
      flag_n    <= 1'b0;
      flag_c    <= 1'b0;
      flag_v    <= 1'b0;
      flag_err  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            if (Control == OP_MUL) begin
              mcand  <= {{WIDTH{1'b0}}, A};
              mplier <= B;
              acc    <= '0;
              count  <= COUNT_INIT;
              state  <= S_BUSY;
            end else begin
              Answer    <= res;
              Answer_hi <= '0;
              flag_z    <= (res == '0);
              flag_n    <= res[WIDTH-1];
              flag_c    <= res_c;
              flag_v    <= res_v;
              flag_err  <= res_err;
              state     <= S_DONE;
            end
          end
        end
        // One multiplier bit per cycle; the final step publishes acc_next directly.
        S_BUSY: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count - 1'b1;
          if (count == COUNT_LAST) begin
            Answer    <= acc_next[WIDTH-1:0];
            Answer_hi <= acc_next[2*WIDTH-1:WIDTH];
            flag_z    <= (acc_next[WIDTH-1:0] == '0);
            flag_n    <= acc_next[WIDTH-1];
            flag_c    <= |acc_next[2*WIDTH-1:WIDTH];
            flag_v    <= 1'b0;
            flag_err  <= 1'b0;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed scenarios plus random ops
// compared against an arithmetic reference model.
module tb_alu_pipe;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [3:0]   Control;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] Answer;
  logic [W-1:0] Answer_hi;
  logic         flag_z;
  logic         flag_n;
  logic         flag_c;
  logic         flag_v;
  logic         flag_err;

  int ncmp = 0;
  int nerr = 0;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         z;
    logic         n;
    logic         c;
    logic         v;
    logic         err;
  } exp_t;

  alu_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Control(Control),
    .out_valid(out_valid), .out_ready(out_ready),
    .Answer(Answer), .Answer_hi(Answer_hi),
    .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c),
    .flag_v(flag_v), .flag_err(flag_err)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference results from plain integer arithmetic on the operands.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op);
    exp_t   e;
    longint ua = longint'(a);
    longint ub = longint'(b);
    int     sa = $signed(a);
    int     sb = $signed(b);
    int     sh = int'(b) % W;
    longint r;
    e.hi = '0; e.lo = '0; e.c = 1'b0; e.v = 1'b0; e.err = 1'b0;
    case (op)
      4'd0: begin
        r = ua + ub; e.lo = W'(r); e.c = (r > 65535);
        e.v = ((sa + sb) > 32767) || ((sa + sb) < -32768);
      end
      4'd1: begin
        r = ua - ub; e.lo = W'(r); e.c = (ua < ub);
        e.v = ((sa - sb) > 32767) || ((sa - sb) < -32768);
      end
      4'd2:  e.lo = a & b;
      4'd3:  e.lo = a | b;
      4'd4:  e.lo = a ^ b;
      4'd5:  e.lo = ~a;
      4'd6:  e.lo = W'(ua << sh);
      4'd7:  e.lo = W'(ua >> sh);
      4'd8:  e.lo = W'(sa >>> sh);
      4'd9:  e.lo = (sa < sb) ? 1 : 0;
      4'd10: e.lo = (ua < ub) ? 1 : 0;
      4'd11: begin
        r = ua * ub; e.lo = W'(r); e.hi = W'(r >> W); e.c = (e.hi != 0);
      end
      4'd12: e.lo = b;
      default: e.err = 1'b1;
    endcase
    e.z = (e.lo == 0);
    e.n = e.lo[W-1];
    return e;
  endfunction

  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op);
    @(negedge clk);
    in_valid = 1'b1; A = a; B = b; Control = op;
    checkOutput($sformatf("in_ready_before_op%0d", op), W'(in_ready), W'(1));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    A = W'($urandom); B = W'($urandom); Control = 4'($urandom);
  endtask

  task automatic awaitResult(input string tag, input int exp_lat);
    int lat = 1;
    bit rdy_seen = 1'b0;
    while (!out_valid && lat < 200) begin
      if (in_ready) rdy_seen = 1'b1;
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    checkOutput({tag, "_latency"}, W'(lat), W'(exp_lat));
    checkOutput({tag, "_ready_while_busy"}, W'(rdy_seen), W'(0));
    checkOutput({tag, "_ready_in_done"}, W'(in_ready), W'(0));
  endtask

  task automatic checkResult(input string tag, input exp_t e);
    checkOutput({tag, "_answer"}, Answer, e.lo);
    checkOutput({tag, "_answer_hi"}, Answer_hi, e.hi);
    checkOutput({tag, "_z"}, W'(flag_z), W'(e.z));
    checkOutput({tag, "_n"}, W'(flag_n), W'(e.n));
    checkOutput({tag, "_c"}, W'(flag_c), W'(e.c));
    checkOutput({tag, "_v"}, W'(flag_v), W'(e.v));
    checkOutput({tag, "_err"}, W'(flag_err), W'(e.err));
  endtask

  task automatic releaseResult(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput({tag, "_valid_after_release"}, W'(out_valid), W'(0));
    checkOutput({tag, "_ready_after_release"}, W'(in_ready), W'(1));
  endtask

  task automatic runOp(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op);
    exp_t e;
    e = model(a, b, op);
    applyStimulus(a, b, op);
    awaitResult(tag, (op == 4'd11) ? W + 1 : 1);
    checkResult(tag, e);
    releaseResult(tag);
  endtask

  initial begin
    exp_t e;
    bit   seen;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    A = '0; B = '0; Control = '0;

    #12;
    checkOutput("reset_answer", Answer, '0);
    checkOutput("reset_answer_hi", Answer_hi, '0);
    checkOutput("reset_out_valid", W'(out_valid), W'(0));
    checkOutput("reset_in_ready", W'(in_ready), W'(0));
    checkOutput("reset_flags", W'({flag_z, flag_n, flag_c, flag_v, flag_err}), W'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("in_ready_after_reset", W'(in_ready), W'(1));

    runOp("add_10_20", 16'd10, 16'd20, 4'd0);
    checkOutput("add_10_20_const", Answer, 16'd30);
    runOp("sub_9_30", 16'd9, 16'd30, 4'd1);
    checkOutput("sub_9_30_const", Answer, 16'hFFEB);
    runOp("add_ovf", 16'h7FFF, 16'd1, 4'd0);
    runOp("mul_300_500", 16'd300, 16'd500, 4'd11);
    checkOutput("mul_hi_const", Answer_hi, 16'h0002);
    checkOutput("mul_lo_const", Answer, 16'h49F0);

    // Backpressure: result must hold while out_ready stays low and in_valid is ignored.
    e = model(16'h8000, 16'h0013, 4'd8);
    applyStimulus(16'h8000, 16'h0013, 4'd8);
    awaitResult("sar_bp", 1);
    checkResult("sar_bp", e);
    checkOutput("sar_bp_const", Answer, 16'hF000);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; A = 16'd1; B = 16'd1; Control = 4'd0;
      @(posedge clk);
      @(negedge clk);
      checkOutput($sformatf("sar_bp_hold_valid_%0d", i), W'(out_valid), W'(1));
      checkOutput($sformatf("sar_bp_hold_answer_%0d", i), Answer, 16'hF000);
      checkOutput($sformatf("sar_bp_hold_ready_%0d", i), W'(in_ready), W'(0));
    end
    in_valid = 1'b0;
    releaseResult("sar_bp");

    // Reset in the middle of a multiply, eight iterations in.
    applyStimulus(16'd3, 16'd5, 4'd11);
    repeat (8) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    checkOutput("midmul_rst_answer", Answer, '0);
    checkOutput("midmul_rst_answer_hi", Answer_hi, '0);
    checkOutput("midmul_rst_valid", W'(out_valid), W'(0));
    checkOutput("midmul_rst_ready", W'(in_ready), W'(0));
    checkOutput("midmul_rst_flags", W'({flag_z, flag_n, flag_c, flag_v, flag_err}), W'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("midmul_ready_after_release", W'(in_ready), W'(1));
    seen = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    checkOutput("midmul_no_valid", W'(seen), W'(0));
    runOp("add_1_1", 16'd1, 16'd1, 4'd0);
    checkOutput("add_1_1_const", Answer, 16'd2);

    runOp("illegal_1110", 16'h1234, 16'h5678, 4'b1110);
    runOp("slt_ffff_1", 16'hFFFF, 16'd1, 4'd9);
    checkOutput("slt_const", Answer, 16'd1);
    runOp("sltu_ffff_1", 16'hFFFF, 16'd1, 4'd10);
    checkOutput("sltu_const", Answer, 16'd0);

    for (int i = 0; i < 40; i++) begin
      runOp($sformatf("rand%0d", i), W'($urandom), W'($urandom), 4'($urandom_range(0, 15)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised successor to the team's 16-bit single-cycle ALU.
- Adds configurable data width, a valid/ready handshake on both sides, and registered status flags.
- Adds an iterative multi-cycle unsigned multiply with a double-width result.
- Sits between the operand/control source (sequencer or testbench driver) and the writeback stage; every output is registered.

Parameters:
- WIDTH, 16: operand and result width in bits; must be at least 4 and a power of 2.
- SHW, $clog2(WIDTH): shift-amount width, derived; do not override.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  operand/opcode valid
- in_ready  out  1  block can accept an operation
- A  in  WIDTH  operand A
- B  in  WIDTH  operand B
- Control  in  4  opcode
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- Answer  out  WIDTH  result, or low half of the product for MUL
- Answer_hi  out  WIDTH  high half of the product for MUL; 0 for all other ops
- flag_z  out  1  Answer == 0
- flag_n  out  1  Answer[WIDTH-1]
- flag_c  out  1  carry/borrow; see rules below
- flag_v  out  1  signed overflow
- flag_err  out  1  illegal opcode

Behaviour:
- Reset: rst=1 forces IDLE immediately. All outputs go to 0, except in_ready=1 once rst is deasserted. The multiply counter and accumulator are cleared.
- Reset mid-operation: any in-flight op is discarded with no out_valid pulse.
- State machine has three states: IDLE, BUSY, DONE.
- in_ready = (state == IDLE). No new operation is accepted in BUSY or DONE.
- Accept: an op is accepted on an edge where in_valid && in_ready; A, B and Control are captured at that edge.
- Non-MUL ops: result is computed and registered on the accept edge, and the state goes IDLE -> DONE. out_valid is high in the following cycle (latency 1).
- MUL: the accept edge loads the multiplicand, multiplier and count=WIDTH, and the state goes IDLE -> BUSY.
  - BUSY runs shift-add, one multiplier bit per cycle.
  - After WIDTH BUSY edges the state goes BUSY -> DONE, so out_valid rises WIDTH+1 edges after accept.
- DONE: out_valid=1. Answer, Answer_hi and all flags are held stable until out_ready=1. On that edge the state goes DONE -> IDLE and out_valid drops the next cycle.
- Throughput: at most one op per 2 cycles (non-MUL) or per WIDTH+2 cycles (MUL).
- Opcodes, with A,B interpreted unsigned unless noted:
  - 0000 ADD: A+B
  - 0001 SUB: A-B
  - 0010 AND
  - 0011 OR
  - 0100 XOR
  - 0101 NOT: ~A
  - 0110 SHL: A<<B[SHW-1:0]
  - 0111 SHR: logical A>>B[SHW-1:0]
  - 1000 SAR: arithmetic A>>>B[SHW-1:0]
  - 1001 SLT: signed A<B ? 1 : 0
  - 1010 SLTU: unsigned compare, same encoding
  - 1011 MUL: unsigned {Answer_hi,Answer} = A*B
  - 1100 PASSB: B
  - 1101–1111 illegal: Answer=0, flag_err=1, latency 1
- Shift amount: only the low SHW bits of B are used; upper bits of B are ignored.
- flag_c:
  - ADD: carry-out.
  - SUB: borrow, i.e. A<B unsigned.
  - MUL: |Answer_hi.
  - All other ops: 0.
- flag_v:
  - ADD: signed overflow, (A[msb]==B[msb]) && (Answer[msb]!=A[msb]).
  - SUB: (A[msb]!=B[msb]) && (Answer[msb]!=A[msb]).
  - All other ops: 0.
- flag_z and flag_n are computed on Answer only, never on Answer_hi. They are valid for every op, including illegal ones (illegal gives z=1, n=0).
- in_valid asserted while in_ready=0 is ignored; the source must hold the operation until it is accepted.
- out_ready asserted while out_valid=0 is ignored.

Test Plan:
- Reset, then ADD with A=10, B=20 -> out_valid high 1 cycle after accept, Answer=30, z=n=c=v=0, Answer_hi=0.
- SUB with A=9, B=30 -> Answer=0xFFEB, n=1, c=1, v=0; ADD with A=0x7FFF, B=1 -> Answer=0x8000, v=1, n=1, c=0.
- MUL with A=300, B=500 -> out_valid exactly 17 edges after accept, Answer_hi=0x0002, Answer=0x49F0, c=1; in_ready=0 throughout BUSY/DONE.
- Backpressure: SAR with A=0x8000, B=0x0013 (amount 3) and out_ready=0 for 5 cycles -> Answer=0xF000 held stable, out_valid held, in_valid ignored. Then out_ready=1 -> returns to IDLE and in_ready=1 next cycle.
- Reset asserted mid-MUL (BUSY, count=8) -> all outputs 0 immediately, no out_valid after release. A following ADD with A=1, B=1 -> Answer=2.
- Control=1110 -> Answer=0, flag_err=1, z=1. SLT with A=0xFFFF, B=1 -> Answer=1; SLTU with the same operands -> Answer=0.
